execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 126 ++++++++++++
 tb/tb_execute_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: ALU plus iterative shift-add MUL feeding writeback_stage; 1-cycle latency, MUL 32 cycles.
// Backpressure: in_ready drops for the whole multiply; inputs presented meanwhile are not taken.
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             reg_wen,
  input  logic [4:0]       wr_reg,
  output logic             reg_wen_out,
  output logic [4:0]       wr_reg_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  // Destination captured at MUL accept, already x0-masked.
  typedef struct packed {
    logic       wen;
    logic [4:0] wr_reg;
  } wb_t;

  logic [0:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  wb_t              mul_wb;
  logic [WIDTH-1:0] op_result;
  logic [4:0]       shamt;

  assign in_ready = (state == ST_IDLE) && rst_n;
  assign busy     = (state == ST_MUL);
  assign shamt    = operand_b[4:0];
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    op_result = '0;
    case (alu_op)
      OP_ADD:  op_result = operand_a + operand_b;
      OP_SUB:  op_result = operand_a - operand_b;
      OP_AND:  op_result = operand_a & operand_b;
      OP_OR:   op_result = operand_a | operand_b;
      OP_XOR:  op_result = operand_a ^ operand_b;
      OP_SLL:  op_result = operand_a << shamt;
      OP_SRL:  op_result = operand_a >> shamt;
      OP_SRA:  op_result = $unsigned($signed(operand_a) >>> shamt);
      OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: op_result = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
      default: op_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      reg_wen_out    <= 1'b0;
      wr_reg_out     <= '0;
      alu_result_out <= '0;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      cnt            <= '0;
      mul_wb         <= '0;
    end else begin
      reg_wen_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (alu_op == OP_MUL) begin
              mcand         <= operand_a;
              mplier        <= operand_b;
              acc           <= '0;
              cnt           <= '0;
              mul_wb.wen    <= reg_wen && (wr_reg != 5'd0);
              mul_wb.wr_reg <= wr_reg;
              state         <= ST_MUL;
            end else begin
              alu_result_out <= op_result;
              wr_reg_out     <= wr_reg;
              reg_wen_out    <= reg_wen && (wr_reg != 5'd0);
            end
          end
        end
        ST_MUL: begin
          // Fixed WIDTH iterations regardless of operand values.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            alu_result_out <= acc_next;
            wr_reg_out     <= mul_wb.wr_reg;
            reg_wen_out    <= mul_wb.wen;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected writes queued at issue, checked when due.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        reg_wen;
  logic [4:0]  wr_reg;
  logic        reg_wen_out;
  logic [4:0]  wr_reg_out;
  logic [31:0] alu_result_out;
  logic        busy;

  execute_stage #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_op         (alu_op),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .reg_wen        (reg_wen),
    .wr_reg         (wr_reg),
    .reg_wen_out    (reg_wen_out),
    .wr_reg_out     (wr_reg_out),
    .alu_result_out (alu_result_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        wen;
    logic [4:0]  wr;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_err  = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return sa >>> b[4:0];
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // Output monitor: a queued write is compared on its due edge, every other edge must be a bubble.
  always @(negedge clk) begin
    chk("x0_guard", {31'd0, reg_wen_out && (wr_reg_out == 5'd0)}, 32'd0);
    if (sb.size() > 0 && sb[0].due == edge_n) begin
      exp_t e;
      e = sb.pop_front();
      chk("wb_wen", {31'd0, reg_wen_out}, {31'd0, e.wen});
      chk("wb_reg", {27'd0, wr_reg_out}, {27'd0, e.wr});
      chk("wb_res", alu_result_out, e.res);
    end else begin
      chk("bubble_wen", {31'd0, reg_wen_out}, 32'd0);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wen, input logic [4:0] wr, input logic [31:0] exp, output int waits);
    exp_t e;
    alu_op    = op;
    operand_a = a;
    operand_b = b;
    reg_wen   = wen;
    wr_reg    = wr;
    in_valid  = 1'b1;
    waits     = 0;
    while (!in_ready && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.due = edge_n + ((op == 4'd10) ? 33 : 1);
      e.wen = wen && (wr != 5'd0);
      e.wr  = wr;
      e.res = exp;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rwr;
    logic        rwen;

    rst_n = 1'b0; in_valid = 1'b0; alu_op = '0;
    operand_a = '0; operand_b = '0; reg_wen = 1'b0; wr_reg = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", {31'd0, reg_wen_out}, 32'd0);
    chk("rst_wr", {27'd0, wr_reg_out}, 32'd0);
    chk("rst_res", alu_result_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    issue(4'd0, 32'd5, 32'd7, 1'b1, 5'd3, 32'd12, w);
    idle(1);
    chk("hold_res", alu_result_out, 32'd12);
    chk("hold_wen", {31'd0, reg_wen_out}, 32'd0);

    // back-to-back single-cycle ops
    issue(4'd1, 32'd0, 32'd1, 1'b1, 5'd4, 32'hFFFF_FFFF, w);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd5, 32'd1, w);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd6, 32'd0, w);
    issue(4'd7, 32'h8000_0000, 32'd36, 1'b1, 5'd8, 32'hF800_0000, w);
    issue(4'd6, 32'h8000_0000, 32'd36, 1'b1, 5'd9, 32'h0800_0000, w);
    issue(4'd5, 32'd1, 32'd31, 1'b1, 5'd10, 32'h8000_0000, w);
    chk("b2b_no_stall", w, 32'd0);
    idle(1);

    // MUL with an ADD held behind it
    issue(4'd10, 32'h0001_0001, 32'h0001_0001, 1'b1, 5'd7, 32'h0002_0001, w);
    chk("mul_busy", {31'd0, busy}, 32'd1);
    chk("mul_not_ready", {31'd0, in_ready}, 32'd0);
    issue(4'd0, 32'd1, 32'd2, 1'b1, 5'd11, 32'd3, w);
    chk("mul_stall_cycles", w, 32'd32);
    idle(1);

    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd12, 32'd1, w);
    idle(33);

    // x0 destination and unused opcode
    issue(4'd0, 32'd1, 32'd1, 1'b1, 5'd0, 32'd2, w);
    idle(1);
    chk("x0_res_updated", alu_result_out, 32'd2);
    issue(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5'd13, 32'd0, w);
    idle(2);

    // reset in the middle of a multiply
    issue(4'd10, 32'd3, 32'd4, 1'b1, 5'd14, 32'd12, w);
    in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    sb.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_wen", {31'd0, reg_wen_out}, 32'd0);
    chk("abort_wr", {27'd0, wr_reg_out}, 32'd0);
    chk("abort_res", alu_result_out, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    idle(40);

    for (int i = 0; i < 24; i++) begin
      rop  = 4'($urandom_range(0, 15));
      ra   = $urandom;
      rb   = $urandom;
      rwr  = 5'($urandom_range(0, 31));
      rwen = 1'($urandom_range(0, 1));
      issue(rop, ra, rb, rwen, rwr, model(rop, ra, rb), w);
    end
    idle(40);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
